duart_tx_sequencer: RTL and testbench
=====================================

Name: duart_tx_sequencer

Overview:
- Sits between the CPU bus and the d2681 DUART register port and owns that port.
- Multiplexes DUART register access between the CPU and an on-chip byte-stream source (console/trace producer).
- Buffers producer bytes in a FIFO. Autonomously polls the channel A status register and writes each byte to the channel A data register when the transmitter is ready.
- The CPU has priority, with a starvation guard so the stream always makes progress.

Parameters:
- FIFO_DEPTH, 8, byte FIFO depth; power of two, ≥2.
- POLL_GAP, 4, clken ticks waited after a not-ready status read before re-polling; ≥1.
- STARVE_LIMIT, 16, consecutive slots the sequencer may lose to the CPU before it takes a slot; ≥1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- clken  in  1  bus-slot strobe; one DUART access per clk cycle with clken=1
- cpu_req  in  1  CPU requests a DUART access (held until cpu_ack)
- cpu_we  in  1  CPU write (1) / read (0)
- cpu_addr  in  4  CPU DUART register address
- cpu_di  in  8  CPU write data
- cpu_do  out  8  CPU read data; valid while cpu_ack=1
- cpu_ack  out  1  CPU access performed in this slot
- tx_valid  in  1  producer byte valid
- tx_data  in  8  producer byte
- tx_ready  out  1  FIFO can accept a byte
- duart_enable  out  1  DUART enable
- duart_we  out  1  DUART write
- duart_addr  out  4  DUART register address
- duart_di  out  8  DUART write data
- duart_do  in  8  DUART read data (combinational from duart_addr)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes held
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (async, reset_n=0):
  - FIFO emptied; FSM enters IDLE; gap and starve counters cleared.
  - All duart_* outputs 0; cpu_ack=0; cpu_do=0; tx_ready=1 once released; fifo_level=0; busy=0.
  - Reset mid-write discards the FIFO contents and the pending byte.
- FIFO:
  - Push on a clk edge with tx_valid & tx_ready.
  - tx_ready = (fifo_level < FIFO_DEPTH).
  - Pop only in the WRITE slot.
  - Push and pop in the same cycle leave the level unchanged. A push cannot occur when full; a pop cannot occur when empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Slot ownership (combinational, evaluated every clk cycle; a slot exists only when clken=1):
  - The sequencer wants the slot in POLL or WRITE.
  - The CPU owns the slot if cpu_req and NOT (sequencer wants it and starve_cnt==STARVE_LIMIT).
  - Otherwise, if the sequencer wants the slot, the sequencer owns it.
  - Otherwise the slot is idle: duart_enable=0.
  - When clken=0: duart_enable=0 and cpu_ack=0.
- CPU slot:
  - duart_enable=1, duart_we=cpu_we, duart_addr=cpu_addr, duart_di=cpu_di.
  - cpu_ack=1 for exactly that cycle; cpu_do=duart_do in that cycle, 0 otherwise.
  - No address filtering: CPU writes to 0x3 are permitted, and the CPU owns RX reads.
- starve_cnt:
  - Increments when the sequencer wants a slot and the CPU takes it.
  - Clears on every sequencer-owned slot.
  - Saturates at STARVE_LIMIT.
- FSM states: IDLE, POLL, WAIT, WRITE.
  - IDLE: if fifo_level≠0, go to POLL next cycle.
  - POLL: on an owned slot, drive read addr 0x1 (duart_we=0) and sample duart_do[2] (TxRDY).
    - TxRDY=1: go to WRITE.
    - TxRDY=0: load gap_cnt=POLL_GAP and go to WAIT.
  - WAIT: decrement gap_cnt on each clken; at 0, go to POLL.
  - WRITE: on an owned slot, drive write addr 0x3 with the FIFO head on duart_di, pop, then go to IDLE. The next byte therefore always re-polls, covering TxRDY deassert latency.
- Lost slots stall the FSM in its current state. A byte is never popped without a completed write slot.
- Producer-to-DUART minimum latency with clken=1 every cycle: push at cycle t, IDLE→POLL at t+1, poll slot at t+2, write slot at t+3.
- busy = (fifo_level≠0) | (state≠IDLE).

Test Plan:
1. Reset release, clken=1 each cycle, push 0x41 with duart_do[2]=1 on addr 1 → read of addr 1 at t+2, write of 0x41 to addr 3 at t+3, fifo_level returns to 0, busy=0 by t+4.
2. TxRDY held 0 for 3 polls, POLL_GAP=4 → addr-1 reads spaced 5 clken slots apart; 0x55 written to addr 3 one slot after the first poll returning TxRDY=1.
3. Push 9 bytes back-to-back with FIFO_DEPTH=8 and TxRDY=0 → tx_ready drops after the 8th push, the 9th is held; with TxRDY=1 the bytes are written in push order 0..7 and then the 9th; the pointer wraps correctly.
4. cpu_req held continuously (read addr 0xD) while the FIFO holds bytes, STARVE_LIMIT=16 → 16 cpu_acks, then one sequencer slot with cpu_ack=0, then the CPU resumes; starve_cnt clears.
5. CPU read of addr 0x5 with an idle sequencer → cpu_ack=1 in the first clken cycle, cpu_do=duart_do; clken low cycles produce no ack and duart_enable=0.
6. reset_n asserted between POLL and WRITE with 3 bytes queued → all outputs 0 immediately, no addr-3 write issued, fifo_level=0 after release.

Source files
------------

// File: rtl/duart_tx_sequencer.sv
// duart_tx_sequencer: shares the d2681 register port between the CPU and a FIFO-buffered byte stream to channel A.
module duart_tx_sequencer #(
  parameter int FIFO_DEPTH   = 8,
  parameter int POLL_GAP     = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clken,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [3:0]                    cpu_addr,
  input  logic [7:0]                    cpu_di,
  output logic [7:0]                    cpu_do,
  output logic                          cpu_ack,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          duart_enable,
  output logic                          duart_we,
  output logic [3:0]                    duart_addr,
  output logic [7:0]                    duart_di,
  input  logic [7:0]                    duart_do,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int GW = $clog2(POLL_GAP + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, POLL, WAIT, WRITE} state_t;
  state_t state, state_nx;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [GW-1:0] gap_cnt, gap_nx;
  logic [SW-1:0] starve_cnt;
  logic seq_want, cpu_own, seq_own, push, pop;
  assign seq_want = state == POLL || state == WRITE;
  // the CPU yields only once the stream has lost STARVE_LIMIT consecutive slots
  assign cpu_own  = reset_n && clken && cpu_req && !(seq_want && starve_cnt == SW'(STARVE_LIMIT));
  assign seq_own  = reset_n && clken && seq_want && !cpu_own;
  assign tx_ready = reset_n && fifo_level < LW'(FIFO_DEPTH);
  assign push     = tx_valid && tx_ready;
  assign pop      = seq_own && state == WRITE;
  assign busy     = fifo_level != '0 || state != IDLE;
  assign duart_enable = cpu_own || seq_own;
  assign duart_we     = cpu_own ? cpu_we : pop;
  assign duart_addr   = cpu_own ? cpu_addr : seq_own ? (pop ? 4'h3 : 4'h1) : 4'h0;
  assign duart_di     = cpu_own ? cpu_di : pop ? mem[rd_ptr] : 8'h00;
  assign cpu_ack      = cpu_own;
  assign cpu_do       = cpu_own ? duart_do : 8'h00;
  always_comb begin
    state_nx = state;
    gap_nx = gap_cnt;
    case (state)
      IDLE: if (fifo_level != '0) state_nx = POLL;
      POLL: if (seq_own) begin
        state_nx = duart_do[2] ? WRITE : WAIT;
        gap_nx = duart_do[2] ? gap_cnt : GW'(POLL_GAP);
      end
      WAIT: if (clken) begin
        gap_nx = gap_cnt - GW'(1);
        state_nx = gap_cnt == GW'(1) ? POLL : WAIT;
      end
      default: if (seq_own) state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gap_cnt    <= '0;
      starve_cnt <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      state   <= state_nx;
      gap_cnt <= gap_nx;
      if (seq_own) starve_cnt <= '0;
      else if (seq_want && cpu_own && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + SW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end
endmodule

// File: tb/tb_duart_tx_sequencer.sv
// tb_duart_tx_sequencer: scenario tasks plus a randomized run scored against a queue model of the byte stream.
module tb_duart_tx_sequencer;
  logic clk = 0, reset_n = 0, clken = 0, cpu_req = 0, cpu_we = 0, tx_valid = 0, txrdy = 0;
  logic [3:0] cpu_addr = 0;
  logic [7:0] cpu_di = 0, tx_data = 0;
  logic [7:0] cpu_do, duart_di, duart_do;
  logic cpu_ack, tx_ready, duart_enable, duart_we, busy;
  logic [3:0] duart_addr, fifo_level;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  duart_tx_sequencer #(.FIFO_DEPTH(8), .POLL_GAP(4), .STARVE_LIMIT(16)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do), .cpu_ack(cpu_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .duart_enable(duart_enable), .duart_we(duart_we), .duart_addr(duart_addr),
    .duart_di(duart_di), .duart_do(duart_do), .fifo_level(fifo_level), .busy(busy));
  function automatic logic [7:0] dev_rd(input logic [3:0] a, input logic r);
    return a == 4'h1 ? {5'b0, r, 2'b0} : {a, ~a};
  endfunction
  assign duart_do = dev_rd(duart_addr, txrdy);
  task automatic test_reset();
    reset_n = 0; clken = 1; cpu_req = 1; cpu_addr = 4'h5; tx_valid = 1; tx_data = 8'hAA;
    @(negedge clk);
    checks++; if ({duart_enable, duart_we, duart_addr, duart_di} !== 14'h0) begin errors++; $display("FAIL rst_duart: got %h expected 0", {duart_enable, duart_we, duart_addr, duart_di}); end
    checks++; if ({cpu_ack, cpu_do} !== 9'h0) begin errors++; $display("FAIL rst_cpu: got %h expected 0", {cpu_ack, cpu_do}); end
    checks++; if ({fifo_level, busy} !== 5'h0) begin errors++; $display("FAIL rst_level: got %h expected 0", {fifo_level, busy}); end
    @(posedge clk); #1;
    reset_n = 1; cpu_req = 0; tx_valid = 0;
    @(negedge clk);
    checks++; if ({tx_ready, fifo_level, busy, duart_enable} !== 7'b1_0000_0_0) begin errors++; $display("FAIL rst_release: got %b expected 1000000", {tx_ready, fifo_level, busy, duart_enable}); end
    @(posedge clk); #1;
  endtask
  task automatic test_latency();
    logic [5:0] ea [5] = '{6'b0_0000_0, 6'b0_0001_1, 6'b1_0001_1, 6'b1_0001_1, 6'b0_0000_0};
    txrdy = 1; clken = 1; tx_valid = 1; tx_data = 8'h41;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++; if ({duart_enable, fifo_level, busy} !== ea[c]) begin errors++; $display("FAIL lat_c%0d: got %b expected %b", c, {duart_enable, fifo_level, busy}, ea[c]); end
      if (c == 2) begin checks++; if ({duart_we, duart_addr} !== 5'b0_0001) begin errors++; $display("FAIL lat_poll: got %b expected 00001", {duart_we, duart_addr}); end end
      if (c == 3) begin checks++; if ({duart_we, duart_addr, duart_di} !== {1'b1, 4'h3, 8'h41}) begin errors++; $display("FAIL lat_write: got %h expected %h", {duart_we, duart_addr, duart_di}, {1'b1, 4'h3, 8'h41}); end end
      @(posedge clk); #1;
      tx_valid = 0;
    end
  endtask
  task automatic test_poll_gap();
    int slot = 0, wslot = -1;
    int polls[$];
    logic [7:0] wdata = 0;
    logic was;
    txrdy = 0; clken = 1; tx_valid = 1; tx_data = 8'h55;
    for (int c = 0; c < 300 && wslot < 0; c++) begin
      @(negedge clk);
      if (duart_enable && !cpu_ack && !duart_we && duart_addr == 4'h1) polls.push_back(slot);
      if (duart_enable && !cpu_ack && duart_we && duart_addr == 4'h3) begin wslot = slot; wdata = duart_di; end
      was = clken;
      @(posedge clk); #1;
      if (was) slot++;
      tx_valid = 0;
      clken = $urandom_range(0, 3) != 0;
      txrdy = polls.size() >= 3;
    end
    checks++; if (polls.size() != 4) begin errors++; $display("FAIL gap_polls: got %0d expected 4", polls.size()); end
    for (int i = 0; i + 1 < polls.size(); i++) begin
      checks++; if (polls[i+1] - polls[i] != 5) begin errors++; $display("FAIL gap_spacing%0d: got %0d expected 5", i, polls[i+1] - polls[i]); end
    end
    if (polls.size() == 4) begin checks++; if (wslot != polls[3] + 1) begin errors++; $display("FAIL gap_wslot: got %0d expected %0d", wslot, polls[3] + 1); end end
    checks++; if (wdata !== 8'h55) begin errors++; $display("FAIL gap_wdata: got %h expected 55", wdata); end
    clken = 1;
  endtask
  task automatic test_fifo_full();
    logic [7:0] exp_b [9];
    logic [7:0] got[$];
    int n = 0;
    logic acc;
    foreach (exp_b[i]) exp_b[i] = 8'($urandom);
    txrdy = 0; clken = 1; tx_valid = 1; tx_data = exp_b[0];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      checks++; if (tx_ready !== (n < 8)) begin errors++; $display("FAIL full_ready_c%0d: got %b expected %b", c, tx_ready, n < 8); end
      acc = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (acc) n++;
      tx_valid = n < 9; tx_data = exp_b[n < 9 ? n : 8];
    end
    checks++; if (fifo_level !== 4'd8 || n != 8) begin errors++; $display("FAIL full_level: got %0d/%0d expected 8/8", fifo_level, n); end
    txrdy = 1;
    for (int c = 0; c < 300 && got.size() < 9; c++) begin
      @(negedge clk);
      if (duart_enable && !cpu_ack && duart_we) got.push_back(duart_di);
      acc = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (acc) n++;
      tx_valid = n < 9; tx_data = exp_b[n < 9 ? n : 8];
    end
    checks++; if (got.size() != 9) begin errors++; $display("FAIL full_count: got %0d expected 9", got.size()); end
    for (int i = 0; i < got.size() && i < 9; i++) begin
      checks++; if (got[i] !== exp_b[i]) begin errors++; $display("FAIL full_order%0d: got %h expected %h", i, got[i], exp_b[i]); end
    end
  endtask
  task automatic test_starve();
    int eg [4] = '{18, 16, 17, 16};
    logic ek [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] b [2];
    int gaps[$];
    logic kinds[$];
    logic [7:0] wd[$];
    int acks = 0, pushed = 0;
    logic acc;
    b[0] = 8'($urandom); b[1] = 8'($urandom);
    txrdy = 1; clken = 1; cpu_req = 1; cpu_we = 0; cpu_addr = 4'hD; tx_valid = 1; tx_data = b[0];
    for (int c = 0; c < 300 && gaps.size() < 4; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        acks++;
        checks++; if (cpu_do !== dev_rd(4'hD, 1'b1)) begin errors++; $display("FAIL starve_cpu_do: got %h expected %h", cpu_do, dev_rd(4'hD, 1'b1)); end
      end else if (duart_enable) begin
        gaps.push_back(acks); kinds.push_back(duart_we);
        if (duart_we) wd.push_back(duart_di);
        acks = 0;
      end
      acc = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (acc) pushed++;
      tx_valid = pushed < 2; tx_data = b[pushed < 2 ? pushed : 1];
    end
    @(negedge clk);
    checks++; if (cpu_ack !== 1'b1) begin errors++; $display("FAIL starve_resume: got %b expected 1", cpu_ack); end
    @(posedge clk); #1;
    cpu_req = 0;
    checks++; if (gaps.size() != 4) begin errors++; $display("FAIL starve_slots: got %0d expected 4", gaps.size()); end
    for (int i = 0; i < gaps.size(); i++) begin
      checks++; if (gaps[i] != eg[i] || kinds[i] !== ek[i]) begin errors++; $display("FAIL starve_gap%0d: got %0d/%b expected %0d/%b", i, gaps[i], kinds[i], eg[i], ek[i]); end
    end
    for (int i = 0; i < wd.size() && i < 2; i++) begin
      checks++; if (wd[i] !== b[i]) begin errors++; $display("FAIL starve_data%0d: got %h expected %h", i, wd[i], b[i]); end
    end
  endtask
  task automatic test_cpu();
    txrdy = 0; clken = 0; cpu_req = 1; cpu_we = 0; cpu_addr = 4'h5;
    for (int c = 0; c < 3; c++) begin
      clken = c == 2;
      @(negedge clk);
      if (c < 2) begin
        checks++; if ({cpu_ack, duart_enable} !== 2'b00) begin errors++; $display("FAIL cpu_noslot%0d: got %b expected 00", c, {cpu_ack, duart_enable}); end
      end else begin
        checks++; if ({cpu_ack, duart_enable, duart_we, duart_addr, cpu_do} !== {3'b110, 4'h5, dev_rd(4'h5, 1'b0)}) begin errors++; $display("FAIL cpu_read: got %h expected %h", {cpu_ack, duart_enable, duart_we, duart_addr, cpu_do}, {3'b110, 4'h5, dev_rd(4'h5, 1'b0)}); end
      end
      @(posedge clk); #1;
    end
    cpu_we = 1; cpu_addr = 4'h3; cpu_di = 8'hA5;
    @(negedge clk);
    checks++; if ({cpu_ack, duart_enable, duart_we, duart_addr, duart_di} !== {3'b111, 4'h3, 8'hA5}) begin errors++; $display("FAIL cpu_write: got %h expected %h", {cpu_ack, duart_enable, duart_we, duart_addr, duart_di}, {3'b111, 4'h3, 8'hA5}); end
    @(posedge clk); #1;
    cpu_req = 0; cpu_we = 0;
    @(negedge clk);
    checks++; if ({cpu_ack, cpu_do, fifo_level} !== 13'h0) begin errors++; $display("FAIL cpu_release: got %h expected 0", {cpu_ack, cpu_do, fifo_level}); end
    @(posedge clk); #1;
  endtask
  task automatic test_random();
    logic [7:0] q[$];
    logic acked, acc;
    for (int c = 0; c < 1200; c++) begin
      @(negedge clk);
      checks++; if (fifo_level !== 4'(q.size()) || tx_ready !== (q.size() < 8)) begin errors++; $display("FAIL rnd_level c%0d: got %0d/%b expected %0d/%b", c, fifo_level, tx_ready, q.size(), q.size() < 8); end
      if (q.size() != 0) begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rnd_busy c%0d: got %b expected 1", c, busy); end end
      if (!(clken && cpu_req)) begin checks++; if (cpu_ack !== 1'b0) begin errors++; $display("FAIL rnd_spurious_ack c%0d: got %b expected 0", c, cpu_ack); end end
      if (!clken) begin checks++; if (duart_enable !== 1'b0) begin errors++; $display("FAIL rnd_noslot c%0d: got %b expected 0", c, duart_enable); end end
      if (cpu_ack) begin
        checks++; if ({duart_enable, duart_we, duart_addr, cpu_do} !== {1'b1, cpu_we, cpu_addr, dev_rd(cpu_addr, txrdy)}) begin errors++; $display("FAIL rnd_cpu c%0d: got %h expected %h", c, {duart_enable, duart_we, duart_addr, cpu_do}, {1'b1, cpu_we, cpu_addr, dev_rd(cpu_addr, txrdy)}); end
      end else if (duart_enable) begin
        checks++; if (duart_addr !== (duart_we ? 4'h3 : 4'h1)) begin errors++; $display("FAIL rnd_seq_addr c%0d: got %h expected %h", c, duart_addr, duart_we ? 4'h3 : 4'h1); end
        if (duart_we) begin
          checks++; if (q.size() == 0 || duart_di !== q[0]) begin errors++; $display("FAIL rnd_wdata c%0d: got %h expected %h (queued %0d)", c, duart_di, q.size() ? q[0] : 8'h00, q.size()); end
          if (q.size() != 0) void'(q.pop_front());
        end
      end
      acc = tx_valid && tx_ready;
      if (acc) q.push_back(tx_data);
      acked = cpu_ack;
      @(posedge clk); #1;
      clken = $urandom_range(0, 3) != 0;
      txrdy = $urandom_range(0, 1) == 1;
      tx_valid = $urandom_range(0, 2) != 0;
      tx_data = 8'($urandom);
      if (acked) cpu_req = 0;
      if (!cpu_req && $urandom_range(0, 3) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 4'($urandom); cpu_di = 8'($urandom);
      end
    end
    cpu_req = 0; tx_valid = 0; clken = 1; txrdy = 1;
    for (int c = 0; c < 200 && (q.size() != 0 || busy); c++) begin
      @(negedge clk);
      if (duart_enable && duart_we) begin
        checks++; if (q.size() == 0 || duart_di !== q[0]) begin errors++; $display("FAIL drain_wdata: got %h expected %h (queued %0d)", duart_di, q.size() ? q[0] : 8'h00, q.size()); end
        if (q.size() != 0) void'(q.pop_front());
      end
      @(posedge clk); #1;
    end
    checks++; if (q.size() != 0 || {busy, fifo_level} !== 5'h0) begin errors++; $display("FAIL drain_done: got %0d/%b/%0d expected 0/0/0", q.size(), busy, fifo_level); end
  endtask
  task automatic test_reset_mid();
    logic seen = 0, acc;
    int pushed = 0;
    txrdy = 1; clken = 1; cpu_req = 0; tx_valid = 1; tx_data = 8'h11;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = duart_enable && !cpu_ack && !duart_we && duart_addr == 4'h1;
      acc = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (acc) pushed++;
      tx_valid = pushed < 3; tx_data = 8'h11 + 8'(pushed);
    end
    checks++; if (!seen || fifo_level !== 4'd3) begin errors++; $display("FAIL mid_setup: got poll=%b level=%0d expected poll=1 level=3", seen, fifo_level); end
    reset_n = 0; tx_valid = 0;
    #1;
    checks++; if ({duart_enable, duart_we, duart_addr, duart_di, cpu_ack, cpu_do, fifo_level, busy} !== 28'h0) begin errors++; $display("FAIL mid_outputs: got %h expected 0", {duart_enable, duart_we, duart_addr, duart_di, cpu_ack, cpu_do, fifo_level, busy}); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (duart_enable !== 1'b0) begin errors++; $display("FAIL mid_held%0d: got %b expected 0", c, duart_enable); end
      @(posedge clk); #1;
    end
    reset_n = 1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++; if ({duart_enable, fifo_level, busy, tx_ready} !== 7'b0_0000_0_1) begin errors++; $display("FAIL mid_after%0d: got %b expected 0000001", c, {duart_enable, fifo_level, busy, tx_ready}); end
      @(posedge clk); #1;
    end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_poll_gap();
    test_fifo_full();
    test_starve();
    test_cpu();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
